// File: rtl/ascon_dec_tag_check_pkg.sv
// Shared types and constants for the Ascon decryption tag checker.
package ascon_dec_tag_check_pkg;

    localparam int unsigned PT_W_DEF  = 32;
    localparam int unsigned TAG_W_DEF = 128;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so index vectors always have a legal width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ascon_dec_tag_check_if.sv
// Stream, expected tag and result handshake between the decryption core side and the checker.
interface ascon_dec_tag_check_if #(
    parameter int unsigned Y     = 32,
    parameter int unsigned TAG_W = 128
);
    logic             decryption_readyxSI;
    logic             plain_textxSI;
    logic             tagxSI;
    logic [TAG_W-1:0] exp_tagxDI;
    logic             pt_readyxSI;
    logic             pt_validxSO;
    logic [Y-1:0]     plain_textxDO;
    logic             auth_okxSO;
    logic             auth_failxSO;
    logic             busyxSO;

    modport master (
        output decryption_readyxSI, plain_textxSI, tagxSI, exp_tagxDI, pt_readyxSI,
        input  pt_validxSO, plain_textxDO, auth_okxSO, auth_failxSO, busyxSO
    );

    modport slave (
        input  decryption_readyxSI, plain_textxSI, tagxSI, exp_tagxDI, pt_readyxSI,
        output pt_validxSO, plain_textxDO, auth_okxSO, auth_failxSO, busyxSO
    );
endinterface

// File: rtl/ascon_dec_tag_check_capture.sv
// Serial-to-parallel register: writes one bit at a given index, synchronous clear.
module ascon_dec_tag_check_capture #(
    parameter int unsigned W     = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_bit,
    output logic [W-1:0]     o_data
);
    logic [W-1:0] r_data;

    // Clear has priority over a bit write; the index is range-checked by the caller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_clr) begin
            r_data <= '0;
        end else if (i_we) begin
            r_data[i_idx] <= i_bit;
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/ascon_dec_tag_check.sv
// Deserialises the decrypted plaintext and tag streams, compares the tag in constant
// time and releases plaintext through valid/ready only when authentication succeeds.
module ascon_dec_tag_check
    import ascon_dec_tag_check_pkg::*;
#(
    parameter int unsigned y     = PT_W_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    ascon_dec_tag_check_if.slave bus
);
    localparam int unsigned MAX_W  = max2(y, TAG_W);
    localparam int unsigned PT_IW  = clog2(y);
    localparam int unsigned TAG_IW = clog2(TAG_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_diff;
    logic               r_abort;
    logic               r_rearm;
    logic [y-1:0]       w_pt_sh;
    logic               w_start;
    logic               w_accept;
    logic               w_last;
    logic               w_sample;
    logic               w_pt_we;
    logic               w_tag_we;
    logic [PT_IW-1:0]   w_pt_idx;
    logic [TAG_IW-1:0]  w_tag_idx;
    logic               w_auth_ok;

    // Rearm blocks a new capture until ready has been seen low after an accept.
    assign w_start   = (r_state == ST_IDLE) && bus.decryption_readyxSI && !r_rearm;
    assign w_accept  = (r_state == ST_DONE) && bus.pt_readyxSI;
    assign w_sample  = (r_state == ST_CAPTURE) && bus.decryption_readyxSI;
    assign w_last    = (r_cnt == CNT_W'(MAX_W - 1));
    assign w_pt_we   = w_sample && (r_cnt < CNT_W'(y));
    assign w_tag_we  = w_sample && (r_cnt < CNT_W'(TAG_W));
    assign w_pt_idx  = r_cnt[PT_IW-1:0];
    assign w_tag_idx = r_cnt[TAG_IW-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode; an abort and the last sampled bit both lead to DONE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_start) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (!bus.decryption_readyxSI || w_last) w_state_nxt = ST_DONE;
            ST_DONE:    if (bus.pt_readyxSI) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit counter, sticky tag-difference accumulator, abort and rearm flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_diff  <= 1'b0;
            r_abort <= 1'b0;
            r_rearm <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && !bus.decryption_readyxSI) r_rearm <= 1'b0;
            if (w_accept) r_rearm <= 1'b1;
            if (w_start) begin
                r_cnt   <= '0;
                r_diff  <= 1'b0;
                r_abort <= 1'b0;
            end
            if (r_state == ST_CAPTURE && !bus.decryption_readyxSI) r_abort <= 1'b1;
            if (w_sample) r_cnt <= r_cnt + CNT_W'(1);
            if (w_tag_we) r_diff <= r_diff | (bus.tagxSI ^ bus.exp_tagxDI[w_tag_idx]);
        end
    end

    ascon_dec_tag_check_capture #(
        .W     (y),
        .IDX_W (PT_IW)
    ) u_pt_capture (
        .clk    (clk),
        .rst_n  (rst),
        .i_clr  (w_start || w_accept),
        .i_we   (w_pt_we),
        .i_idx  (w_pt_idx),
        .i_bit  (bus.plain_textxSI),
        .o_data (w_pt_sh)
    );

    // Result outputs decoded from state; plaintext is gated off unless authenticated.
    always_comb begin
        w_auth_ok         = (r_state == ST_DONE) && !r_diff && !r_abort;
        bus.pt_validxSO   = (r_state == ST_DONE);
        bus.auth_okxSO    = w_auth_ok;
        bus.auth_failxSO  = (r_state == ST_DONE) && (r_diff || r_abort);
        bus.plain_textxDO = w_auth_ok ? w_pt_sh : '0;
        bus.busyxSO       = (r_state == ST_CAPTURE) || (r_state == ST_DONE);
    end
endmodule

// File: tb/tb_ascon_dec_tag_check.sv
// Directed bench for the Ascon decryption tag checker.
module tb_ascon_dec_tag_check;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    localparam logic [127:0] EXP_TAG = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [31:0]  PT      = 32'hDEADBEEF;

    ascon_dec_tag_check_if #(.Y(32), .TAG_W(128)) bus ();

    ascon_dec_tag_check #(.y(32), .TAG_W(128), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 128'(bus.pt_validxSO), 128'd0);
        check({tag, "_ok"},    128'(bus.auth_okxSO), 128'd0);
        check({tag, "_fail"},  128'(bus.auth_failxSO), 128'd0);
        check({tag, "_pt"},    128'(bus.plain_textxDO), 128'd0);
        check({tag, "_busy"},  128'(bus.busyxSO), 128'd0);
    endtask

    // mode 0: full stream, 1: ready drops at bit stop_at, 2: reset at bit stop_at.
    task automatic run_stream(input logic [31:0] pt, input logic [127:0] tag,
                              input int mode, input int stop_at, input bit keep_rdy);
        @(negedge clk);
        bus.decryption_readyxSI = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            if (mode == 1 && k == stop_at) begin
                bus.decryption_readyxSI = 1'b0;
                @(posedge clk);
                @(negedge clk);
                return;
            end
            if (mode == 2 && k == stop_at) begin
                rst = 1'b0;
                bus.decryption_readyxSI = 1'b0;
                #1;
                check_idle_outputs("rst_mid");
                @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (k == 1)   check("busy_capture", 128'(bus.busyxSO), 128'd1);
            if (k == 127) check("latency_pre", 128'(bus.pt_validxSO), 128'd0);
            bus.plain_textxSI = (k < 32) ? pt[k] : 1'b0;
            bus.tagxSI        = tag[k];
            @(posedge clk);
        end
        @(negedge clk);
        if (!keep_rdy) bus.decryption_readyxSI = 1'b0;
        check("latency_valid", 128'(bus.pt_validxSO), 128'd1);
    endtask

    task automatic accept();
        bus.pt_readyxSI = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.pt_readyxSI = 1'b0;
        check("accept_valid", 128'(bus.pt_validxSO), 128'd0);
        check("accept_pt", 128'(bus.plain_textxDO), 128'd0);
    endtask

    initial begin
        logic [127:0] bad_tag;
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.decryption_readyxSI = 1'b0;
        bus.plain_textxSI = 1'b0;
        bus.tagxSI = 1'b0;
        bus.exp_tagxDI = EXP_TAG;
        bus.pt_readyxSI = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // 1: matching tag releases plaintext
        run_stream(PT, EXP_TAG, 0, 0, 1'b0);
        check("t1_pt",   128'(bus.plain_textxDO), 128'(PT));
        check("t1_ok",   128'(bus.auth_okxSO), 128'd1);
        check("t1_fail", 128'(bus.auth_failxSO), 128'd0);
        check("t1_busy", 128'(bus.busyxSO), 128'd1);
        accept();

        // 2: MSB of the tag flipped
        bad_tag = EXP_TAG;
        bad_tag[127] = ~bad_tag[127];
        run_stream(PT, bad_tag, 0, 0, 1'b0);
        check("t2_fail", 128'(bus.auth_failxSO), 128'd1);
        check("t2_ok",   128'(bus.auth_okxSO), 128'd0);
        check("t2_pt",   128'(bus.plain_textxDO), 128'd0);
        accept();

        // 2b: LSB of the tag flipped
        bad_tag = EXP_TAG;
        bad_tag[0] = ~bad_tag[0];
        run_stream(PT, bad_tag, 0, 0, 1'b0);
        check("t2b_fail", 128'(bus.auth_failxSO), 128'd1);
        check("t2b_pt",   128'(bus.plain_textxDO), 128'd0);
        accept();

        // 3: backpressure holds the result stable
        run_stream(32'h12345678, EXP_TAG, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 128'(bus.pt_validxSO), 128'd1);
            check("t3_hold_pt", 128'(bus.plain_textxDO), 128'h12345678);
            check("t3_hold_ok", 128'(bus.auth_okxSO), 128'd1);
        end
        accept();

        // 4: stream aborted at bit 50
        run_stream(PT, EXP_TAG, 1, 50, 1'b0);
        check("t4_valid", 128'(bus.pt_validxSO), 128'd1);
        check("t4_fail",  128'(bus.auth_failxSO), 128'd1);
        check("t4_ok",    128'(bus.auth_okxSO), 128'd0);
        check("t4_pt",    128'(bus.plain_textxDO), 128'd0);
        accept();

        // 5: reset at bit 70, then a clean stream
        run_stream(PT, EXP_TAG, 2, 70, 1'b0);
        @(negedge clk);
        check_idle_outputs("t5_post_rst");
        run_stream(32'hCAFE0001, EXP_TAG, 0, 0, 1'b0);
        check("t5_ok", 128'(bus.auth_okxSO), 128'd1);
        check("t5_pt", 128'(bus.plain_textxDO), 128'hCAFE0001);
        accept();

        // 6: ready held high after accept must not restart capture
        run_stream(PT, EXP_TAG, 0, 0, 1'b1);
        check("t6_ok", 128'(bus.auth_okxSO), 128'd1);
        accept();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_no_recapture", 128'(bus.busyxSO), 128'd0);
        end
        bus.decryption_readyxSI = 1'b0;
        @(negedge clk);
        check("t6_idle_low", 128'(bus.busyxSO), 128'd0);
        bus.decryption_readyxSI = 1'b1;
        @(negedge clk);
        check("t6_recapture", 128'(bus.busyxSO), 128'd1);
        bus.decryption_readyxSI = 1'b0;
        @(negedge clk);
        check("t6_abort_fail", 128'(bus.auth_failxSO), 128'd1);
        accept();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
